// File: rtl/matrix_pkg.sv
// matrix_pkg: shared widths, loader state encoding and matrix word type for the matrix datapath.
package matrix_pkg;
  localparam int ELEM_W_DEF = 8;
  localparam int NUM_ELEMS_DEF = 16;
  localparam int MATRIX_W = ELEM_W_DEF * NUM_ELEMS_DEF;
  typedef enum logic [1:0] {LD_FILL, LD_CHECK, LD_HOLD} loader_state_t;
  typedef logic [MATRIX_W-1:0] matrix_word_t;
endpackage

// File: rtl/matrix_pack_shift.sv
// matrix_pack_shift: element-wide shift register; oldest element ends up in the MSBs.
module matrix_pack_shift
  import matrix_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int NUM_ELEMS = NUM_ELEMS_DEF
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic [ELEM_W-1:0]           data_in,
  output logic [ELEM_W*NUM_ELEMS-1:0] data_out
);
  localparam int W = ELEM_W * NUM_ELEMS;
  logic [W-1:0] r_word;
  always_ff @(posedge clock) begin
    if (rst || clr) r_word <= '0;
    else if (en) r_word <= {r_word[W-ELEM_W-1:0], data_in};
  end
  assign data_out = r_word;
endmodule

// File: rtl/matrix_word_loader.sv
// matrix_word_loader: packs NUM_ELEMS streamed elements into one matrix word with valid/ready on both sides.
// Define MATRIX_LOADER_CKSUM_EN to require a trailing XOR checksum element before a word is released.
module matrix_word_loader
  import matrix_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int NUM_ELEMS = NUM_ELEMS_DEF,
  localparam int CNT_W = $clog2(NUM_ELEMS + 1)
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [ELEM_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [ELEM_W*NUM_ELEMS-1:0] out_word,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CNT_W-1:0]            elem_count,
  output logic                        cksum_err
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ELEMS - 1);
`ifdef MATRIX_LOADER_CKSUM_EN
  localparam loader_state_t AFTER_FILL = LD_CHECK;
`else
  localparam loader_state_t AFTER_FILL = LD_HOLD;
`endif
  loader_state_t    r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             w_accept, w_shift_en, w_clr;
  assign in_ready   = (r_state == LD_FILL) || (r_state == LD_CHECK);
  assign out_valid  = r_state == LD_HOLD;
  assign elem_count = r_count;
  assign w_accept   = in_valid && in_ready && !flush;
`ifdef MATRIX_LOADER_CKSUM_EN
  logic [ELEM_W-1:0] r_cksum;
  logic              r_err, w_err_nxt, w_ck_ok;
  assign w_ck_ok   = in_data == r_cksum;
  assign cksum_err = r_err;
  // first element of a word restarts the running XOR, so no separate clear is needed
  always_ff @(posedge clock) begin
    if (rst) r_cksum <= '0;
    else if (w_shift_en) r_cksum <= (r_count == '0) ? in_data : r_cksum ^ in_data;
    r_err <= rst ? 1'b0 : w_err_nxt;
  end
`else
  assign cksum_err = 1'b0;
`endif
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_shift_en  = 1'b0;
    w_clr       = 1'b0;
`ifdef MATRIX_LOADER_CKSUM_EN
    w_err_nxt   = 1'b0;
`endif
    if (flush) begin
      w_state_nxt = LD_FILL;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        LD_FILL: if (w_accept) begin
          w_shift_en  = 1'b1;
          w_count_nxt = r_count + 1'b1;
          w_state_nxt = (r_count == LAST) ? AFTER_FILL : LD_FILL;
        end
`ifdef MATRIX_LOADER_CKSUM_EN
        LD_CHECK: if (w_accept) begin
          w_state_nxt = w_ck_ok ? LD_HOLD : LD_FILL;
          w_count_nxt = w_ck_ok ? r_count : '0;
          w_err_nxt   = !w_ck_ok;
          w_clr       = !w_ck_ok;
        end
`endif
        LD_HOLD: if (out_ready) begin
          w_state_nxt = LD_FILL;
          w_count_nxt = '0;
        end
        default: begin
          w_state_nxt = LD_FILL;
          w_count_nxt = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= LD_FILL;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end
  matrix_pack_shift #(.ELEM_W(ELEM_W), .NUM_ELEMS(NUM_ELEMS)) u_shift (
    .clock   (clock),
    .rst     (rst),
    .clr     (w_clr),
    .en      (w_shift_en),
    .data_in (in_data),
    .data_out(out_word)
  );
endmodule
